// File: rtl/alu_cmd_link.sv
// rtl/alu_cmd_link.sv - byte-serial command assembler and result returner for the 8-bit ALU
module alu_cmd_link #(
    parameter int         TIMEOUT  = 16,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] data,
    output logic        data_valid,
    input  logic [15:0] result,
    input  logic        result_valid,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        GET_A    = 3'd0,
        GET_B    = 3'd1,
        GET_OP   = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RES = 3'd4,
        SEND_HI  = 3'd5,
        SEND_LO  = 3'd6
    } state_t;

    // Counter value seen in the last permitted WAIT_RES cycle
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [15:0] res_reg;
    logic [7:0]  cnt;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the purely state-derived handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        data_valid = 1'b0;
        case (state)
            GET_A: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = GET_B;
            end
            GET_B: begin
                in_ready = 1'b1;
                if (in_valid) state_next = GET_OP;
            end
            GET_OP: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ISSUE;
            end
            ISSUE: begin
                data_valid = 1'b1;
                state_next = WAIT_RES;
            end
            WAIT_RES: begin
                // A result in the final cycle still beats the timeout
                if (result_valid || cnt == CNT_LAST) state_next = SEND_HI;
            end
            SEND_HI: begin
                if (out_ready) state_next = SEND_LO;
            end
            SEND_LO: begin
                if (out_ready) state_next = GET_A;
            end
            default: state_next = GET_A;
        endcase
    end

    // Operand capture, command word, wait counter and registered byte output
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg       <= 8'h00;
            b_reg       <= 8'h00;
            data        <= 24'h000000;
            res_reg     <= 16'h0000;
            cnt         <= 8'h00;
            out_byte    <= 8'h00;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    if (in_valid) a_reg <= in_byte;
                end
                GET_B: begin
                    if (in_valid) b_reg <= in_byte;
                end
                GET_OP: begin
                    if (in_valid) begin
                        data        <= {a_reg, b_reg, in_byte};
                        timeout_err <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt <= 8'h00;
                end
                WAIT_RES: begin
                    if (result_valid) begin
                        res_reg   <= result;
                        out_byte  <= result[15:8];
                        out_valid <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        res_reg     <= {ERR_BYTE, ERR_BYTE};
                        out_byte    <= ERR_BYTE;
                        out_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SEND_HI: begin
                    if (out_ready) out_byte <= res_reg[7:0];
                end
                SEND_LO: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
